// File: rtl/sr_latch_driver.sv
// Clocked command stage that turns set/clear requests into non-overlapping,
// width-controlled S/R pulses and confirms the outcome through synchronized Q/QB.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic req_ready,
    output logic s_out,
    output logic r_out,
    input  logic q_in,
    input  logic qb_in,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_state
);

    localparam int MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAXV   = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
    localparam int CW     = $clog2(MAXV + 1);

    localparam logic [CW-1:0] PULSE_C   = CW'(PULSE_W);
    localparam logic [CW-1:0] GAP_C     = CW'(GAP_W);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          target_q, target_d;
    logic          s_q, s_d, r_q, r_d;
    logic          done_q, done_d, err_q, err_d;
    logic          qst_q, qst_d;
    logic          q_s1_q, q_s_q, qb_s1_q, qb_s_q;
    logic          match;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // A racing latch (q == qb) can never satisfy both terms, so it is a no-match.
    assign match   = (q_s_q == target_q) && (qb_s_q == ~target_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        qst_d    = qst_q;
        case (state_q)
            IDLE: begin
                if (set_req && clr_req) begin
                    err_d = 1'b1;
                end else if (set_req ^ clr_req) begin
                    target_d = set_req;
                    s_d      = set_req;
                    r_d      = clr_req;
                    cnt_d    = CNT_ONE;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q >= PULSE_C) begin
                    cnt_d   = CNT_ONE;
                    state_d = CHECK;
                end else begin
                    s_d   = target_q;
                    r_d   = ~target_q;
                    cnt_d = cnt_inc;
                end
            end
            CHECK: begin
                if (match) begin
                    done_d  = 1'b1;
                    qst_d   = target_q;
                    cnt_d   = CNT_ONE;
                    state_d = GAP;
                end else if (cnt_q >= TIMEOUT_C) begin
                    err_d   = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            qst_q    <= 1'b0;
            q_s1_q   <= 1'b0;
            q_s_q    <= 1'b0;
            qb_s1_q  <= 1'b0;
            qb_s_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            err_q    <= err_d;
            qst_q    <= qst_d;
            q_s1_q   <= q_in;
            q_s_q    <= q_s1_q;
            qb_s1_q  <= qb_in;
            qb_s_q   <= qb_s1_q;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign q_state   = qst_q;

endmodule
